// File: rtl/freqdiv_pkg.sv
// Shared types and defaults for the fractional clock-enable divider.
package freqdiv_pkg;

    localparam int unsigned FREQDIV_W = 8;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_INT    = 2'b01,
        MODE_FRAC   = 2'b10
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_LOAD,
        S_SETTLE,
        S_RUN
    } state_t;

endpackage

// File: rtl/frac_ce_gen.sv
// Fractional clock-enable generator: accumulator-based div_out/div_in pulse train.
module frac_ce_gen
    import freqdiv_pkg::*;
#(
    parameter int unsigned W = FREQDIV_W
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] ld_div_in,
    input  logic [W-1:0] ld_div_out,
    output logic         pulse
);

    logic [W-1:0] div_in_q;
    logic [W-1:0] div_out_q;
    logic [W:0]   acc_q;
    logic [W:0]   sum;

    // Pulse when this cycle's accumulation crosses the numerator.
    always_comb begin
        sum   = acc_q + {1'b0, div_out_q};
        pulse = (sum >= {1'b0, div_in_q});
    end

    // Ratio registers and accumulator; acc stays below div_in so W+1 bits never overflow.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_in_q  <= '0;
            div_out_q <= '0;
            acc_q     <= '0;
        end else if (load) begin
            div_in_q  <= ld_div_in;
            div_out_q <= ld_div_out;
            acc_q     <= '0;
        end else if (en) begin
            acc_q <= pulse ? (sum - {1'b0, div_in_q}) : sum;
        end
    end

endmodule

// File: rtl/freqdiv_ctrl.sv
// Ratio reconfiguration controller for the fractional clock-enable divider.
// Optional macro FREQDIV_CTRL_DRAIN_EN: DRAIN keeps the old ce_out pattern
// until the old generator pulses, instead of a single blanked cycle.
module freqdiv_ctrl
    import freqdiv_pkg::*;
#(
    parameter int unsigned W      = FREQDIV_W,
    parameter int unsigned SETTLE = 4
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_div_in,
    input  logic [W-1:0] req_div_out,
    output logic         ce_out,
    output logic [1:0]   mode,
    output logic         busy,
    output logic         locked,
    output logic         cfg_err
);

    localparam int unsigned CW = $clog2(SETTLE + 1);

    state_t        state_q, state_n;
    mode_t         mode_q, sh_mode_q;
    logic [W-1:0]  sh_div_in_q, sh_div_out_q;
    logic [CW-1:0] settle_cnt_q;
    logic          cfg_err_q;

    logic ready_c, ce_c, accept, legal, gen_load, gen_en, gen_pulse;

    frac_ce_gen #(.W(W)) u_gen (
        .clk_in     (clk_in),
        .rst        (rst),
        .load       (gen_load),
        .en         (gen_en),
        .ld_div_in  (sh_div_in_q),
        .ld_div_out (sh_div_out_q),
        .pulse      (gen_pulse)
    );

    // Next-state, handshake and clock-enable decode.
    always_comb begin
        state_n  = state_q;
        ce_c     = 1'b0;
        gen_en   = 1'b0;
        gen_load = 1'b0;
        ready_c  = (state_q == S_IDLE) || (state_q == S_RUN);
        legal    = (req_div_out != '0) && (req_div_in >= req_div_out);
        accept   = req_valid && ready_c;
        case (state_q)
            S_IDLE: ce_c = 1'b1;
            S_DRAIN: begin
`ifdef FREQDIV_CTRL_DRAIN_EN
                // Bypass counts as an every-cycle pulse, so draining from IDLE takes one cycle.
                if (mode_q == MODE_BYPASS) begin
                    ce_c    = 1'b1;
                    state_n = S_LOAD;
                end else begin
                    ce_c   = gen_pulse;
                    gen_en = 1'b1;
                    if (gen_pulse) state_n = S_LOAD;
                end
`else
                state_n = S_LOAD;
`endif
            end
            S_LOAD: begin
                gen_load = 1'b1;
                state_n  = S_SETTLE;
            end
            S_SETTLE: if (settle_cnt_q == '0) state_n = S_RUN;
            S_RUN: begin
                ce_c   = gen_pulse;
                gen_en = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (accept) state_n = legal ? S_DRAIN : S_IDLE;
    end

    // State, shadow ratio, mode, settle counter and error pulse.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_BYPASS;
            sh_mode_q    <= MODE_BYPASS;
            sh_div_in_q  <= '0;
            sh_div_out_q <= '0;
            settle_cnt_q <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cfg_err_q <= accept && !legal;
            if (accept && legal) begin
                sh_div_in_q  <= req_div_in;
                sh_div_out_q <= req_div_out;
                sh_mode_q    <= (req_div_out == W'(1)) ? MODE_INT : MODE_FRAC;
            end
            if (accept && !legal) mode_q <= MODE_BYPASS;
            else if (state_q == S_LOAD) mode_q <= sh_mode_q;
            if (state_q == S_LOAD) settle_cnt_q <= CW'(SETTLE - 1);
            else if (state_q == S_SETTLE && settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - CW'(1);
        end
    end

    // IDLE decodes to ready/bypass, so those two outputs are gated by rst to read 0 during reset.
    assign ce_out    = rst && ce_c;
    assign req_ready = rst && ready_c;
    assign busy      = (state_q == S_DRAIN) || (state_q == S_LOAD) || (state_q == S_SETTLE);
    assign locked    = (state_q == S_RUN);
    assign mode      = mode_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_freqdiv_ctrl.sv
// Directed self-checking bench for freqdiv_ctrl (W=8, SETTLE=4).
module tb_freqdiv_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_div_in = '0;
    logic [7:0] req_div_out = '0;
    logic       ce_out;
    logic [1:0] mode;
    logic       busy;
    logic       locked;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    freqdiv_ctrl #(.W(8), .SETTLE(4)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_div_in  (req_div_in),
        .req_div_out (req_div_out),
        .ce_out      (ce_out),
        .mode        (mode),
        .busy        (busy),
        .locked      (locked),
        .cfg_err     (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk_in);
        #3 rst = 1'b1;
        #1;
    endtask

    // Accept a legal request and wait for RUN cycle 1.
    task automatic go_run(input logic [7:0] di, input logic [7:0] dv);
        req_div_in = di;
        req_div_out = dv;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL go_run_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        #3;
        obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
        checks++;
        if (obs !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_hold: got %b required 0000000", obs);
        end
        repeat (2) @(posedge clk_in);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
            checks++;
            if (obs !== 7'b1100000) begin
                errors++;
                $display("FAIL idle_bypass cyc%0d: got %b required 1100000", i, obs);
            end
            tick();
        end
    endtask

    task automatic test_frac();
        logic [4:0] obs5, exp5;
        logic [6:0] obs, exp;
        do_reset();
        req_div_in = 8'd3;
        req_div_out = 8'd2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
`ifdef FREQDIV_CTRL_DRAIN_EN
            exp5 = {(i == 0), 4'b0100};
`else
            exp5 = 5'b00100;
`endif
            obs5 = {ce_out, req_ready, busy, locked, cfg_err};
            checks++;
            if (obs5 !== exp5) begin
                errors++;
                $display("FAIL frac_busy cyc%0d: got %b required %b", i, obs5, exp5);
            end
            tick();
        end
        for (int k = 1; k <= 6; k++) begin
            exp = {(k % 3 != 1), 4'b1010, 2'b10};
            obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL frac_run k%0d: got %b required %b", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_int();
        logic [6:0] obs, exp;
        do_reset();
        go_run(8'd5, 8'd1);
        for (int k = 1; k <= 15; k++) begin
            exp = {(k % 5 == 0), 4'b1010, 2'b01};
            obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL int_run k%0d: got %b required %b", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [6:0] obs;
        logic [7:0] di [3] = '{8'd2, 8'd4, 8'd2};
        logic [7:0] dv [3] = '{8'd3, 8'd0, 8'd3};
        do_reset();
        for (int n = 0; n < 3; n++) begin
            if (n == 2) go_run(8'd3, 8'd2);
            req_div_in = di[n];
            req_div_out = dv[n];
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
            checks++;
            if (obs !== 7'b1100100) begin
                errors++;
                $display("FAIL illegal_err n%0d: got %b required 1100100", n, obs);
            end
            tick();
            obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
            checks++;
            if (obs !== 7'b1100000) begin
                errors++;
                $display("FAIL illegal_after n%0d: got %b required 1100000", n, obs);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] obs5, exp5;
        logic [6:0] obs, exp;
        int nb;
        do_reset();
        go_run(8'd3, 8'd2);
        tick();
        tick();
        req_div_in = 8'd4;
        req_div_out = 8'd1;
        req_valid = 1'b1;
        obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
        checks++;
        if (obs !== 7'b1101010) begin
            errors++;
            $display("FAIL reprog_accept: got %b required 1101010", obs);
        end
        tick();
        req_valid = 1'b0;
`ifdef FREQDIV_CTRL_DRAIN_EN
        nb = 7;
`else
        nb = 6;
`endif
        for (int i = 0; i < nb; i++) begin
`ifdef FREQDIV_CTRL_DRAIN_EN
            exp5 = {(i == 1), 4'b0100};
`else
            exp5 = 5'b00100;
`endif
            obs5 = {ce_out, req_ready, busy, locked, cfg_err};
            checks++;
            if (obs5 !== exp5) begin
                errors++;
                $display("FAIL reprog_busy cyc%0d: got %b required %b", i, obs5, exp5);
            end
            tick();
        end
        for (int k = 1; k <= 8; k++) begin
            exp = {(k % 4 == 0), 4'b1010, 2'b01};
            obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reprog_run k%0d: got %b required %b", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_settle();
        logic [6:0] obs;
        do_reset();
        req_div_in = 8'd3;
        req_div_out = 8'd2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
        checks++;
        if (obs !== 7'b0000000) begin
            errors++;
            $display("FAIL settle_reset_async: got %b required 0000000", obs);
        end
        repeat (2) @(posedge clk_in);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            obs = {ce_out, req_ready, busy, locked, cfg_err, mode};
            checks++;
            if (obs !== 7'b1100000) begin
                errors++;
                $display("FAIL settle_reset_idle cyc%0d: got %b required 1100000", i, obs);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_frac();
        test_int();
        test_illegal();
        test_back_to_back();
        test_reset_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freqdiv_ctrl.md
FREQDIV_CTRL -- requirements
Module: freqdiv_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: bit width of both ratio operands.
REQ-002 SHALL have parameter SETTLE, default 4: settle cycles (≥1) between LOAD and RUN.
REQ-003 SHALL have port clk_in, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: host presents a ratio request.
REQ-006 SHALL have port req_ready, output, 1: controller accepts a request this cycle.
REQ-007 SHALL have port req_div_in, input, W: ratio numerator (input cycles).
REQ-008 SHALL have port req_div_out, input, W: ratio denominator (output pulses).
REQ-009 SHALL have port ce_out, output, 1: divided clock-enable pulse.
REQ-010 SHALL have port mode, output, 2: active mode; 00 BYPASS, 01 INT, 10 FRAC.
REQ-011 SHALL have port busy, output, 1: reconfiguration in progress.
REQ-012 SHALL have port locked, output, 1: programmed ratio running.
REQ-013 SHALL have port cfg_err, output, 1: single-cycle illegal-request pulse.

Function
REQ-014 SHALL use states IDLE, DRAIN, LOAD, SETTLE, RUN; IDLE is the post-reset state.
REQ-015 SHALL drive req_ready=1 only in IDLE and RUN; accept occurs on a rising edge with req_valid&&req_ready.
REQ-016 SHALL classify an accepted request as: illegal if div_out==0 or div_in<div_out; INT if div_out==1; FRAC otherwise (div_in==div_out is legal FRAC).
REQ-017 SHALL, on an illegal accept, pulse cfg_err for exactly one cycle after the accepting edge, set mode=00, locked=0, next state IDLE, busy=0.
REQ-018 SHALL, on a legal accept, enter DRAIN on the accepting edge and latch the ratio and mode into shadow registers.
REQ-019 SHALL drive busy=1 in DRAIN, LOAD, SETTLE and busy=0 elsewhere.
REQ-020 SHALL, in IDLE, drive ce_out=1 every cycle (bypass pass-through).
REQ-021 SHALL, in LOAD (exactly 1 cycle), copy shadow ratio to the generator, clear its accumulator, update mode, drive ce_out=0.
REQ-022 SHALL, in SETTLE, hold ce_out=0 for exactly SETTLE cycles, then enter RUN.
REQ-023 SHALL, in RUN, drive locked=1; at RUN cycle k (k=1 first), ce_out=1 iff floor(k*div_out/div_in) > floor((k-1)*div_out/div_in).
REQ-024 SHALL implement REQ-023 with a W+1-bit accumulator: acc+=div_out; if acc≥div_in then acc-=div_in and pulse; no overflow is permitted.
REQ-025 SHALL deassert locked in every state except RUN.
REQ-026 SHALL accept a new request while in RUN and resequence through DRAIN (legal) or return to IDLE (illegal).

Reset
REQ-027 SHALL, while rst=0, asynchronously force state IDLE, ce_out=0, mode=00, busy=0, locked=0, cfg_err=0, req_ready=0, accumulator and shadow registers to 0.
REQ-028 SHALL, on reset assertion in any state including mid-DRAIN or mid-SETTLE, abandon the sequence with no pending request retained.

Configuration
REQ-029 SHALL honour macro FREQDIV_CTRL_DRAIN_EN: when defined, DRAIN keeps the old ce_out pattern until the old generator emits a pulse, leaving DRAIN the cycle after that pulse (1 cycle from IDLE).
REQ-030 SHALL, without FREQDIV_CTRL_DRAIN_EN, last exactly 1 cycle in DRAIN with ce_out=0.

Structure
REQ-031 SHALL place the mode and state enumerations and default W in shared package freqdiv_pkg.
REQ-032 SHALL instantiate one sub-module frac_ce_gen holding the accumulator and pulse logic, with load/enable controlled by freqdiv_ctrl.

Verification
REQ-033 SHALL cover: release rst, no request -> ce_out=1 every cycle, mode=00, locked=0, req_ready=1.
REQ-034 SHALL cover: request 3/2 from IDLE -> busy 1+1+4 cycles, then RUN ce_out pattern 0,1,1 repeating, mode=10, locked=1.
REQ-035 SHALL cover: request 5/1 -> mode=01, ce_out=1 on RUN cycles 5,10,15.
REQ-036 SHALL cover: requests 2/3 and 4/0 -> one-cycle cfg_err each, mode=00, ce_out constant 1, busy never asserted.
REQ-037 SHALL cover: in RUN at 3/2, request 4/1 -> with macro, old pattern continues to next pulse before LOAD; without macro, ce_out=0 from next cycle; then pulse every 4th RUN cycle.
REQ-038 SHALL cover: rst=0 during SETTLE -> all outputs reset immediately; after release, IDLE bypass with ce_out=1.
